instr_fetch_ctrl: RTL
=====================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32: number of instruction words in program memory.
REQ-002 Parameter DATA_WIDTH, default 32: width of address, instruction and counter paths.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset; word-aligned.
REQ-004 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-007 Start  input  1  level; moves controller from IDLE to RUN.
REQ-008 Ready_i  input  1  decode stage accepts the output word this cycle.
REQ-009 Redirect  input  1  branch/jump taken; overrides sequential fetch.
REQ-010 RedirectAddr  input  DATA_WIDTH  target address when Redirect=1.
REQ-011 Instruction_i  input  DATA_WIDTH  combinational read data from program memory for PC_o.
REQ-012 PC_o  output  DATA_WIDTH  program memory address, equal to the PC register.
REQ-013 IF_Instruction  output  DATA_WIDTH  registered instruction offered to decode.
REQ-014 IF_PCPlus4  output  DATA_WIDTH  registered address of IF_Instruction plus 4.
REQ-015 IF_Valid  output  1  IF_Instruction/IF_PCPlus4 hold a valid word.
REQ-016 Halted  output  1  controller in HALTED state.
REQ-017 Fault  output  1  sticky; misaligned redirect or out-of-range PC.
REQ-018 FetchCount  output  DATA_WIDTH  number of words accepted by decode since reset.

Function
REQ-019 States: IDLE, RUN, HALTED; the state register shall be a 2-bit encoded register.
REQ-020 IDLE: PC held, nothing captured; Start=1 -> RUN next cycle.
REQ-021 Slot free means IF_Valid=0, or IF_Valid=1 with Ready_i=1.
REQ-022 RUN, slot free, no Redirect, Instruction_i != HALT_WORD: capture Instruction_i and PC_o+4 into output register, set IF_Valid=1, advance PC by 4; latency is one cycle from PC_o to IF_Valid.
REQ-023 RUN, IF_Valid=1, Ready_i=0: PC, IF_Instruction, IF_PCPlus4 and IF_Valid hold.
REQ-024 A handshake (IF_Valid=1 and Ready_i=1) increments FetchCount by 1, in any state; it wraps modulo 2^DATA_WIDTH.
REQ-025 Redirect=1 in RUN, aligned, regardless of Ready_i: PC <= RedirectAddr, IF_Valid <= 0, no capture; this takes priority over REQ-022/REQ-023.
REQ-026 Redirect=1 with RedirectAddr[1:0] != 0: Fault <= 1, state -> HALTED, IF_Valid <= 0.
REQ-027 RUN, slot free, Instruction_i == HALT_WORD: word not captured, IF_Valid <= 0 unless the current word is not yet accepted, PC held, state -> HALTED.
REQ-028 RUN, PC_o[DATA_WIDTH-1:2] >= MEMORY_DEPTH, where the index is PC_o shifted right by 2: Fault <= 1, state -> HALTED, no capture.
REQ-029 HALTED: PC frozen; Start and Redirect are ignored; an already valid word drains normally via Ready_i; only reset exits.
REQ-030 Redirect and Start in IDLE: Redirect is ignored in IDLE.
REQ-031 PC arithmetic is modulo 2^DATA_WIDTH; PC+4 overflow wraps, and the out-of-range rule in REQ-028 then applies.

Reset
REQ-032 With reset=0 at a rising edge, the next state shall be: state=IDLE, PC=RESET_PC, IF_Instruction=0, IF_PCPlus4=0, IF_Valid=0, Halted=0, Fault=0, FetchCount=0.
REQ-033 Reset asserted mid-operation, including HALTED or a pending handshake, shall discard all state, and the pending handshake shall not count.

Verification
REQ-034 Reset, Start=1, Ready_i=1, memory words 0..3 = 0x20080001.. -> IF_Valid rises one cycle after RUN; PC_o sequence 0,4,8,12; FetchCount=3 after three handshakes.
REQ-035 Ready_i=0 for 3 cycles while IF_Valid=1 at PC 0x8 -> PC_o stays 0xC, IF_Instruction stable, FetchCount unchanged; Ready_i=1 -> resumes with 0xC.
REQ-036 Redirect=1, RedirectAddr=0x14, with Ready_i=0 -> next cycle PC_o=0x14, IF_Valid=0; following cycle IF_PCPlus4=0x18.
REQ-037 Word at 0x10 = HALT_WORD -> the word at 0xC is delivered, then Halted=1, PC_o=0x10 frozen, and Start/Redirect pulses have no effect.
REQ-038 RedirectAddr=0x6 -> Fault=1, Halted=1; RedirectAddr=0x80 with MEMORY_DEPTH=32 -> Fault=1 on the next fetch.
REQ-039 reset=0 during a stalled valid word -> all outputs at reset values after one edge, FetchCount=0.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives the program-memory address, registers the
// fetched word toward decode with a valid/ready handshake, and stops on halt or fault.
module instr_fetch_ctrl #(
  parameter int unsigned                MEMORY_DEPTH = 32,
  parameter int unsigned                DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC     = '0,
  parameter logic [DATA_WIDTH-1:0]      HALT_WORD    = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Ready_i,
  input  logic                  Redirect,
  input  logic [DATA_WIDTH-1:0] RedirectAddr,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] IF_Instruction,
  output logic [DATA_WIDTH-1:0] IF_PCPlus4,
  output logic                  IF_Valid,
  output logic                  Halted,
  output logic                  Fault,
  output logic [DATA_WIDTH-1:0] FetchCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

  logic                  handshake;
  logic                  slot_free;
  logic                  out_of_range;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_idx;

  assign handshake    = valid_q & Ready_i;
  assign slot_free    = ~valid_q | Ready_i;
  assign pc_plus4     = pc_q + DATA_WIDTH'(4);
  assign pc_idx       = pc_q >> 2;
  assign out_of_range = (pc_idx >= DATA_WIDTH'(MEMORY_DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    // An offered word drains on handshake unless something below refills or kills it.
    valid_d = valid_q & ~Ready_i;
    fault_d = fault_q;
    cnt_d   = cnt_q + DATA_WIDTH'(handshake);

    unique case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_RUN;
      end
      S_RUN: begin
        if (Redirect) begin
          valid_d = 1'b0;
          if (RedirectAddr[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALTED;
          end else begin
            pc_d = RedirectAddr;
          end
        end else if (out_of_range) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else if (slot_free) begin
          if (Instruction_i == HALT_WORD) begin
            state_d = S_HALTED;
          end else begin
            instr_d = Instruction_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_o           = pc_q;
  assign IF_Instruction = instr_q;
  assign IF_PCPlus4     = pc4_q;
  assign IF_Valid       = valid_q;
  assign Halted         = (state_q == S_HALTED);
  assign Fault          = fault_q;
  assign FetchCount     = cnt_q;

endmodule
